// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_if
// Desc     : Control, ROM and ALU signal bundle for the alu_seq sequencer.
// Revision : 1.0
// ============================================================================
interface alu_seq_if #(
    parameter int PC_W = 8
) ();
    logic              start_i;
    logic [PC_W-1:0]   start_addr_i;
    logic              busy_o;
    logic              done_o;
    logic [PC_W-1:0]   rom_addr_o;
    logic [15:0]       rom_data_i;
    logic [2:0]        alu_a_addr_o;
    logic [2:0]        alu_b_addr_o;
    logic [2:0]        alu_op_o;
    logic              alu_cin_o;
    logic              alu_zero_in_o;
    logic              alu_cout_i;
    logic              alu_ovf_i;
    logic              alu_zero_i;
    logic              alu_neg_i;
    logic [3:0]        flags_o;

    modport slave (
        input  start_i, start_addr_i, rom_data_i,
        input  alu_cout_i, alu_ovf_i, alu_zero_i, alu_neg_i,
        output busy_o, done_o, rom_addr_o,
        output alu_a_addr_o, alu_b_addr_o, alu_op_o, alu_cin_o, alu_zero_in_o,
        output flags_o
    );

    modport master (
        output start_i, start_addr_i, rom_data_i,
        output alu_cout_i, alu_ovf_i, alu_zero_i, alu_neg_i,
        input  busy_o, done_o, rom_addr_o,
        input  alu_a_addr_o, alu_b_addr_o, alu_op_o, alu_cin_o, alu_zero_in_o,
        input  flags_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Desc     : Microsequencer fetching 16-bit instructions from a synchronous
//            ROM, driving an external ALU and branching on its saved flags.
// Revision : 1.0
// ============================================================================
module alu_seq #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  wire       clk,
    input  wire       rst_n,
    alu_seq_if.slave  bus
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_FETCH  = 3'd1;
    localparam logic [2:0] c_ST_DECODE = 3'd2;
    localparam logic [2:0] c_ST_EXEC   = 3'd3;
    localparam logic [2:0] c_ST_FLAGS  = 3'd4;
    localparam logic [2:0] c_ST_BRANCH = 3'd5;

    localparam logic [2:0] c_OP_JMP  = 3'b000;
    localparam logic [2:0] c_OP_JZ   = 3'b001;
    localparam logic [2:0] c_OP_JNZ  = 3'b010;
    localparam logic [2:0] c_OP_JC   = 3'b011;
    localparam logic [2:0] c_OP_JN   = 3'b100;
    localparam logic [2:0] c_OP_JV   = 3'b101;
    localparam logic [2:0] c_OP_HALT = 3'b110;

    localparam logic [2:0]      c_IDLE_OP = 3'b010;
    localparam logic [PC_W-1:0] c_PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_target;
    logic [IW-1:0]   r_ir;
    logic [3:0]      r_flags;
    logic            w_is_ctl;
    logic            w_is_halt;
    logic            w_taken;
    logic            w_flag_c;
    logic            w_flag_v;
    logic            w_flag_z;
    logic            w_flag_n;
    logic [2:0]      w_a;
    logic [2:0]      w_b;
    logic [2:0]      w_op;
    logic            w_cin;
    logic            w_zin;
    logic            w_busy;
    logic            w_done;

    assign w_pc_inc  = r_pc + c_PC_ONE;
    assign w_target  = r_ir[PC_W-1:0];
    assign w_is_ctl  = r_ir[IW-1];
    assign w_is_halt = w_is_ctl && (r_ir[14:12] == c_OP_HALT);

    assign w_flag_c = r_flags[3];
    assign w_flag_v = r_flags[2];
    assign w_flag_z = r_flags[1];
    assign w_flag_n = r_flags[0];

    // Branch condition evaluated against the flags saved by the last ALU op
    always_comb begin
        w_taken = 1'b0;
        case (r_ir[14:12])
            c_OP_JMP: w_taken = 1'b1;
            c_OP_JZ:  w_taken = w_flag_z;
            c_OP_JNZ: w_taken = ~w_flag_z;
            c_OP_JC:  w_taken = w_flag_c;
            c_OP_JN:  w_taken = w_flag_n;
            c_OP_JV:  w_taken = w_flag_v;
            default:  w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   w_state_nxt = bus.start_i ? c_ST_FETCH : c_ST_IDLE;
            c_ST_FETCH:  w_state_nxt = c_ST_DECODE;
            c_ST_DECODE: w_state_nxt = bus.rom_data_i[15] ? c_ST_BRANCH : c_ST_EXEC;
            c_ST_EXEC:   w_state_nxt = c_ST_FLAGS;
            c_ST_FLAGS:  w_state_nxt = c_ST_FETCH;
            c_ST_BRANCH: w_state_nxt = w_is_halt ? c_ST_IDLE : c_ST_FETCH;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_flags <= 4'b0000;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start_i) begin
                        r_pc <= bus.start_addr_i;
                    end
                end
                c_ST_DECODE: begin
                    r_ir <= bus.rom_data_i;
                end
                c_ST_FLAGS: begin
                    r_flags <= {bus.alu_cout_i, bus.alu_ovf_i, bus.alu_zero_i, bus.alu_neg_i};
                    r_pc    <= w_pc_inc;
                end
                c_ST_BRANCH: begin
                    r_pc <= w_taken ? w_target : w_pc_inc;
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

    // ALU ports are parked at a harmless op outside EXEC
    always_comb begin
        w_a    = 3'd0;
        w_b    = 3'd0;
        w_op   = c_IDLE_OP;
        w_cin  = 1'b0;
        w_zin  = 1'b1;
        w_busy = (r_state != c_ST_IDLE);
        w_done = (r_state == c_ST_BRANCH) && w_is_halt;
        if (r_state == c_ST_EXEC) begin
            w_a  = r_ir[11:9];
            w_b  = r_ir[8:6];
            w_op = r_ir[14:12];
            case (r_ir[5:4])
                2'b00:   w_cin = 1'b0;
                2'b01:   w_cin = 1'b1;
                2'b10:   w_cin = w_flag_c;
                default: w_cin = ~w_flag_c;
            endcase
            w_zin = r_ir[3] ? w_flag_z : 1'b1;
        end
    end

    assign bus.busy_o        = w_busy;
    assign bus.done_o        = w_done;
    assign bus.rom_addr_o    = r_pc;
    assign bus.alu_a_addr_o  = w_a;
    assign bus.alu_b_addr_o  = w_b;
    assign bus.alu_op_o      = w_op;
    assign bus.alu_cin_o     = w_cin;
    assign bus.alu_zero_in_o = w_zin;
    assign bus.flags_o       = r_flags;

endmodule
`default_nettype wire
